// File: rtl/and4_path_sequencer.sv
// Self-test sequencer for a 4-input AND-tree cell: walks all 16 vectors in Gray order,
// waits a pin/state-dependent settle time per step, then checks dut_out against &vec_out.
// Optional macro PATHSEQ_FIRST_FAIL_EN adds first_fail_vld / first_fail_vec capture.
module and4_path_sequencer #(
    parameter int T_A1   = 9,
    parameter int T_A0   = 10,
    parameter int T_BC1  = 9,
    parameter int T_BC0  = 13,
    parameter int T_CD01 = 11,
    parameter int T_CDX  = 13,
    parameter int T_INIT = 13,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic [3:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_cnt,
    output logic       pass
`ifdef PATHSEQ_FIRST_FAIL_EN
    ,
    output logic       first_fail_vld,
    output logic [3:0] first_fail_vec
`endif
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    localparam logic [CW-1:0] t_a1   = CW'(T_A1);
    localparam logic [CW-1:0] t_a0   = CW'(T_A0);
    localparam logic [CW-1:0] t_bc1  = CW'(T_BC1);
    localparam logic [CW-1:0] t_bc0  = CW'(T_BC0);
    localparam logic [CW-1:0] t_cd01 = CW'(T_CD01);
    localparam logic [CW-1:0] t_cdx  = CW'(T_CDX);
    localparam logic [CW-1:0] t_init = CW'(T_INIT);

    state_t        state, state_nxt;
    logic [3:0]    idx;
    logic [3:0]    idx_prev;
    logic [3:0]    gray_cur;
    logic [3:0]    gray_prev;
    logic [3:0]    toggled;
    logic [CW-1:0] cnt;
    logic [CW-1:0] settle_sel;
    logic          mismatch;
    logic [4:0]    err_nxt;

    assign idx_prev  = idx - 4'd1;
    assign gray_cur  = idx ^ (idx >> 1);
    assign gray_prev = idx_prev ^ (idx_prev >> 1);
    assign toggled   = gray_cur ^ gray_prev;
    assign mismatch  = (dut_out != (&vec_out));
    assign err_nxt   = mismatch ? err_cnt + 5'd1 : err_cnt;

    // Settle time mirrors the cell's conditional delay for the toggled pin, judged on the new vector.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        settle_sel = t_init;
        if (idx != 4'd0) begin
            if (toggled[3])
                settle_sel = gray_cur[3] ? t_a1 : t_a0;
            else if (toggled[2])
                settle_sel = (gray_cur[2] & gray_cur[1]) ? t_bc1 : t_bc0;
            else
                settle_sel = (gray_cur[1:0] == 2'b01) ? t_cd01 : t_cdx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (cnt == CW'(1)) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == 4'd15) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_out        <= 4'd0;
            err_cnt        <= 5'd0;
            pass           <= 1'b0;
            idx            <= 4'd0;
            cnt            <= '0;
`ifdef PATHSEQ_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_vec <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt        <= 5'd0;
                        pass           <= 1'b0;
                        idx            <= 4'd0;
`ifdef PATHSEQ_FIRST_FAIL_EN
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= 4'd0;
`endif
                    end
                end
                APPLY: begin
                    vec_out <= gray_cur;
                    cnt     <= settle_sel;
                end
                SETTLE: cnt <= cnt - CW'(1);
                CHECK: begin
                    err_cnt <= err_nxt;
`ifdef PATHSEQ_FIRST_FAIL_EN
                    if (mismatch && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_vec <= vec_out;
                    end
`endif
                    // pass is settled on entry to DONE so it is already valid during the done pulse.
                    if (idx == 4'd15) pass <= (err_nxt == 5'd0);
                    else              idx  <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and4_path_sequencer.sv
// Directed bench for and4_path_sequencer: ideal, stuck-at, delayed-cell, reset-abort and
// back-to-back runs, with hand-computed Gray order, settle lengths and error counts.
module tb_and4_path_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b;
    logic [1:0]  mode;  // 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 delayed by 12 cycles
    logic [11:0] pipe_a = '0;
    logic [11:0] pipe_b = '0;
    logic        dut_out_a, dut_out_b;
    logic [3:0]  vec_a, vec_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [4:0]  err_a, err_b;
`ifdef PATHSEQ_FIRST_FAIL_EN
    logic        ffv_a, ffv_b;
    logic [3:0]  ffvec_a, ffvec_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) begin
        pipe_a <= {pipe_a[10:0], &vec_a};
        pipe_b <= {pipe_b[10:0], &vec_b};
    end

    assign dut_out_a = (mode == 2'd0) ? &vec_a :
                       (mode == 2'd1) ? 1'b0   :
                       (mode == 2'd2) ? 1'b1   : pipe_a[11];
    assign dut_out_b = pipe_b[11];

    and4_path_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start_a), .dut_out(dut_out_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .err_cnt(err_a), .pass(pass_a)
`ifdef PATHSEQ_FIRST_FAIL_EN
        , .first_fail_vld(ffv_a), .first_fail_vec(ffvec_a)
`endif
    );

    and4_path_sequencer #(.T_CDX(10)) u_cdx (
        .clk(clk), .reset(reset), .start(start_b), .dut_out(dut_out_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .err_cnt(err_b), .pass(pass_b)
`ifdef PATHSEQ_FIRST_FAIL_EN
        , .first_fail_vld(ffv_b), .first_fail_vec(ffvec_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse sampled at edge k, then count edges until done is seen (bounded).
    task automatic run(input bit sel_b, output int cyc);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        while (!(sel_b ? done_b : done_a) && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    int settle_tab [16] = '{13, 11, 13, 13, 9, 13, 11, 13, 9, 11, 13, 13, 13, 13, 11, 13};

    initial begin
        int r, e, cyc, gap, dones;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 2'd0;
        repeat (3) tick();
        check("rst_vec", vec_a, 4'h0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_err", err_a, 5'd0);
        check("rst_pass", pass_a, 1'b0);
`ifdef PATHSEQ_FIRST_FAIL_EN
        check("rst_ffv", ffv_a, 1'b0);
`endif
        reset = 1'b0;
        tick();

        // Ideal cell: exact vector order and change edges; vector i lands at edge k+e.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        r = 0;
        e = 1;
        check("apply_busy", busy_a, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start_a = 1'b1;  // ignored while busy
                tick(); r++;
                start_a = 1'b0;
            end
            while (r < e - 1) begin tick(); r++; end
            if (i > 0) check($sformatf("hold_%0d", i), vec_a, gray_tab[i-1]);
            tick(); r++;
            check($sformatf("vec_%0d", i), vec_a, gray_tab[i]);
            e += settle_tab[i] + 2;
        end
        while (r < 223) begin tick(); r++; end
        check("ideal_done_early", done_a, 1'b0);
        tick(); r++;
        check("ideal_done_224", done_a, 1'b1);
        check("ideal_err", err_a, 5'd0);
        check("ideal_busy_done", busy_a, 1'b1);
        start_a = 1'b1;  // ignored in the DONE cycle
        tick();
        start_a = 1'b0;
        check("ideal_done_pulse", done_a, 1'b0);
        check("ideal_pass", pass_a, 1'b1);
        check("ideal_idle", busy_a, 1'b0);
        tick();
        check("done_start_ignored", busy_a, 1'b0);
        check("vec_hold", vec_a, 4'h8);

        mode = 2'd1;
        run(1'b0, cyc);
        check("s0_len", cyc, 224);
        check("s0_err", err_a, 5'd1);
`ifdef PATHSEQ_FIRST_FAIL_EN
        check("s0_ffv", ffv_a, 1'b1);
        check("s0_ffvec", ffvec_a, 4'hF);
`endif
        tick();
        check("s0_pass", pass_a, 1'b0);

        mode = 2'd2;
        run(1'b0, cyc);
        check("s1_len", cyc, 224);
        check("s1_err", err_a, 5'd15);
`ifdef PATHSEQ_FIRST_FAIL_EN
        check("s1_ffv", ffv_a, 1'b1);
        check("s1_ffvec", ffvec_a, 4'h0);
`endif
        tick();
        check("s1_pass", pass_a, 1'b0);

        mode = 2'd3;
        run(1'b0, cyc);
        check("dly_err", err_a, 5'd0);
`ifdef PATHSEQ_FIRST_FAIL_EN
        check("dly_ffv", ffv_a, 1'b0);
`endif
        tick();
        check("dly_pass", pass_a, 1'b1);

        // T_CDX=10: eight 13-cycle steps shrink by 3, and both steps into/out of F go stale.
        run(1'b1, cyc);
        check("cdx_len", cyc, 200);
        check("cdx_err", err_b, 5'd2);
`ifdef PATHSEQ_FIRST_FAIL_EN
        check("cdx_ffvec", ffvec_b, 4'hF);
`endif
        tick();
        check("cdx_pass", pass_b, 1'b0);

        // Mid-run reset with errors already counted.
        mode = 2'd2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (100) tick();
        check("pre_rst_err_nz", (err_a != 5'd0), 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy_a, 1'b0);
        check("abort_vec", vec_a, 4'h0);
        check("abort_err", err_a, 5'd0);
        check("abort_done", done_a, 1'b0);
        dones = 0;
        repeat (250) begin
            tick();
            if (done_a) dones++;
        end
        check("abort_no_done", dones, 0);
        mode = 2'd0;
        run(1'b0, cyc);
        check("post_rst_len", cyc, 224);
        check("post_rst_err", err_a, 5'd0);
        repeat (2) tick();

        // start held high: back-to-back runs, DONE then one IDLE cycle between them.
        start_a = 1'b1;
        cyc = 0;
        while (!done_a && cyc < 400) begin tick(); cyc++; end
        check("held_first_done", done_a, 1'b1);
        tick();
        gap = 1;
        while (!done_a && gap < 400) begin tick(); gap++; end
        start_a = 1'b0;
        check("held_gap", (gap >= 225 && gap <= 226), 1'b1);
        check("held_err", err_a, 5'd0);
        repeat (2) tick();
        check("held_stop", busy_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
